// File: rtl/xbar_egress_buffer.sv
// xbar_egress_buffer
//
// Egress stage for one crossbar output port. Each crossbar output word carries
// a valid flag in bit [WIDTH] and a payload in bits [WIDTH-1:0]. Valid words
// are written into a first-word-fall-through FIFO. The FIFO drains to the link
// through a valid/ready handshake.
//
// The crossbar cannot be back-pressured. A word that arrives while the FIFO is
// full and is not being drained in the same cycle is therefore dropped and
// counted. almost_full is exported so that the arbiters can throttle early.
//
// Ports:
//   clk          clock; every state change happens on its rising edge
//   rst          asynchronous, active-high reset
//   in_word      crossbar output word: [WIDTH] = valid, [WIDTH-1:0] = payload
//   out_data     payload at the head of the FIFO
//   out_valid    out_data holds a stored word
//   out_ready    downstream takes the head word this cycle
//   level        number of stored words (0..DEPTH)
//   empty        level == 0
//   full         level == DEPTH
//   almost_full  level >= AF_THRESH
//   drop_cnt     count of dropped words; saturates at 16'hFFFF
//   clr_drop     synchronous clear of drop_cnt; a drop in the same cycle
//                leaves the count at 1
module xbar_egress_buffer #(
    parameter int WIDTH     = 320,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH:0]             in_word,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [15:0]                drop_cnt,
    input  logic                       clr_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic push;
    logic pop;
    logic accept;
    logic drop;

    // The clear wins over a plain increment. A drop in the clearing cycle still
    // counts, so the counter restarts at 1. The count never wraps past 16'hFFFF.
    function automatic logic [15:0] next_drop_cnt(input logic [15:0] cnt,
                                                   input logic        dropped,
                                                   input logic        clr);
        if (clr)
            return dropped ? 16'd1 : 16'd0;
        if (dropped && (cnt != 16'hFFFF))
            return cnt + 16'd1;
        return cnt;
    endfunction

    assign push   = in_word[WIDTH];
    assign pop    = out_valid & out_ready;
    // When the FIFO is full, a simultaneous pop frees the slot that this write
    // fills. The write therefore still fits.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // The flags are decoded from the registered level. They are valid right
    // after the edge that updates level.
    assign empty       = (level == '0);
    assign full        = (level == LW'(DEPTH));
    assign almost_full = (level >= LW'(AF_THRESH));

    // FWFT: the head word is read combinationally, so it is visible on the
    // cycle after it is written.
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            // Clearing the array keeps out_data at zero while in reset. Old
            // words cannot reappear later.
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= in_word[WIDTH-1:0];
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            drop_cnt <= next_drop_cnt(drop_cnt, drop, clr_drop);
        end
    end

endmodule

// File: doc/xbar_egress_buffer.md
Name: xbar_egress_buffer

Overview:
- Per-output-port egress stage downstream of crossbar16x16. One instance per crossbar output.
- Consumes one crossbar output word: bit [WIDTH] is the valid flag, bits [WIDTH-1:0] are the payload.
- Buffers payloads in a first-word-fall-through FIFO and presents them to the link with a valid/ready handshake.
- The crossbar has no backpressure, so overflow drops the word and counts it. almost_full is exported as a throttle hint for the arbiters.

Parameters:
- WIDTH, 320, payload width; the input word is WIDTH+1 bits.
- DEPTH, 16, FIFO entries; must be a power of 2 and >= 4.
- AF_THRESH, 12, level at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_word  input  WIDTH+1  crossbar output word; [WIDTH]=valid, [WIDTH-1:0]=payload.
- out_data  output  WIDTH  head-of-FIFO payload.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- level  output  $clog2(DEPTH)+1  number of words stored.
- empty  output  1  level==0.
- full  output  1  level==DEPTH.
- almost_full  output  1  level>=AF_THRESH.
- drop_cnt  output  16  count of dropped words; saturates at 16'hFFFF.
- clr_drop  input  1  synchronous clear of drop_cnt.

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high. While rst=1, regardless of clk:
  - out_valid=0, level=0, empty=1, full=0, almost_full=0, drop_cnt=0.
  - out_data=0; read and write pointers=0.
  - Stored contents are discarded.
- Reset mid-operation: in-flight words are lost. No word is presented after reset deasserts until a new write.
- Push and pop:
  - push = in_word[WIDTH]. Every cycle with in_word[WIDTH]=1 is one new word; there is no deduplication of repeated values.
  - pop = out_valid & out_ready.
- Write acceptance:
  - A push is accepted if full=0, or if full=1 and pop=1 in the same cycle.
  - An accepted push stores the payload at wr_ptr and advances wr_ptr.
- Drop:
  - A push with full=1 and pop=0 is dropped. The payload is discarded, and drop_cnt increments by 1 unless it is already 16'hFFFF.
- Level update per cycle:
  - accepted push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
  - level never exceeds DEPTH and never underflows.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Flags: full, empty and almost_full are decoded from the registered level and reflect the value after the edge.
- FWFT latency:
  - A word accepted at edge N with the FIFO empty gives out_valid=1 and out_data=payload after edge N.
  - That is one cycle from in_word sampling to visibility.
- Output behaviour:
  - out_valid = ~empty.
  - out_data always equals the word at rd_ptr.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Pop on empty: out_ready while out_valid=0 is ignored and has no state change.
- Ordering: strict FIFO. No reordering and no duplication.
- Push into empty with out_ready=1 in the same cycle: no pop occurs, because out_valid was 0. The word appears on the next cycle.
- clr_drop:
  - The clear takes priority.
  - If clr_drop=1 and a drop occurs in the same cycle, drop_cnt becomes 1.
  - Otherwise clr_drop=1 sets drop_cnt to 0.
- Storage: a register array is sufficient. Reads are combinational from the array via rd_ptr, so there is no extra read latency.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst asynchronously mid-cycle with level=5.
  - Required response: immediately out_valid=0, level=0, empty=1, drop_cnt=0. After release with no pushes, everything stays idle.
- FWFT latency:
  - Stimulus: single push of payload 0xA5 (zero-extended) with out_ready=1.
  - Required response: out_valid=1 with out_data=0xA5 one cycle after sampling. It pops the following edge; level goes 0->1->0.
- Backpressure/order:
  - Stimulus: out_ready=0; push 1..16 on consecutive cycles with DEPTH=16.
  - Required response: level reaches 16, full=1, almost_full asserts when level reaches 12. Then with out_ready=1, words emerge 1..16 in order, one per cycle, and empty=1 at the end.
- Overflow/drop:
  - Stimulus: full FIFO, out_ready=0; push 3 more words.
  - Required response: drop_cnt=3, level=16, and contents are unchanged.
  - Stimulus: assert clr_drop together with one more drop.
  - Required response: drop_cnt=1.
- Full with simultaneous push and pop:
  - Stimulus: level=16, out_ready=1, push 0x77.
  - Required response: no drop, level stays 16, head advances, and 0x77 is the 16th word out.
- Wrap and saturation:
  - Stimulus: 100 continuous push+pop cycles with incrementing data.
  - Required response: pointers wrap cleanly and output equals input delayed by one cycle.
  - Stimulus: force 65537 drops.
  - Required response: drop_cnt holds at 0xFFFF.
